// File: rtl/run_sequencer.sv
// Program-run controller: init cycle, per-instruction PC advance, load stretching,
// halt/timeout detection and run cycle counting for the 9-bit core.
module run_sequencer #(
    parameter int unsigned      MEM_LAT    = 1,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       Instruction,
    input  logic             RegWrEnIn,
    input  logic             MemWrEnIn,
    output logic             PCInit,
    output logic             PCEn,
    output logic             RegWrEn,
    output logic             MemWrEn,
    output logic             Busy,
    output logic             Done,
    output logic             Timeout,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_LDWAIT,
        S_DONE
    } state_t;

    localparam logic [2:0]       LAT        = 3'(MEM_LAT);
    localparam logic [CNT_W-1:0] LAST_CYCLE = MAX_CYCLES - 1'b1;

    state_t           state, state_next;
    logic [2:0]       wait_cnt, wait_next;
    logic [CNT_W-1:0] cycle_cnt;
    logic             done_q, timeout_q;
    logic             to_timeout;
    logic             halt, is_load, budget_hit, running;

    assign halt       = (Instruction == 9'h1FF);
    assign is_load    = (Instruction[8:4] == 5'b01000);
    assign budget_hit = (cycle_cnt == LAST_CYCLE);
    assign running    = (state == S_RUN) || (state == S_LDWAIT);

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        to_timeout = 1'b0;
        PCEn       = 1'b0;
        RegWrEn    = 1'b0;
        MemWrEn    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) state_next = S_INIT;
            end
            S_INIT: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    state_next = S_DONE;
                end else if (budget_hit) begin
                    state_next = S_DONE;
                    to_timeout = 1'b1;
                end else if (is_load && (LAT != 3'd0)) begin
                    state_next = S_LDWAIT;
                    wait_next  = LAT;
                end else begin
                    PCEn    = 1'b1;
                    RegWrEn = RegWrEnIn;
                    MemWrEn = MemWrEnIn;
                end
            end
            S_LDWAIT: begin
                // The budget check wins over a load that would complete this cycle.
                if (budget_hit) begin
                    state_next = S_DONE;
                    to_timeout = 1'b1;
                end else if (wait_cnt == 3'd1) begin
                    state_next = S_RUN;
                    wait_next  = 3'd0;
                    PCEn       = 1'b1;
                    RegWrEn    = RegWrEnIn;
                end else begin
                    wait_next = wait_cnt - 3'd1;
                end
            end
            S_DONE: begin
                if (!Start) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; the asynchronous reset clears all of them, not just the state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            cycle_cnt <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state == S_IDLE && Start) begin
                cycle_cnt <= '0;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end else if (running) begin
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
                if (state_next == S_DONE) begin
                    done_q    <= 1'b1;
                    timeout_q <= to_timeout;
                end
            end
        end
    end

    assign PCInit     = (state == S_INIT);
    assign Busy       = (state == S_INIT) || running;
    assign Done       = done_q;
    assign Timeout    = timeout_q;
    assign CycleCount = cycle_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer (MEM_LAT=1, MAX_CYCLES=8): straight-line run,
// load stretching, timeout inside a load wait, restart handshake, reset mid-load.
module tb_run_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [8:0]  Instruction;
    logic        RegWrEnIn;
    logic        MemWrEnIn;
    logic        PCInit, PCEn, RegWrEn, MemWrEn, Busy, Done, Timeout;
    logic [15:0] CycleCount;

    int total = 0;
    int bad   = 0;

    run_sequencer #(
        .MEM_LAT   (1),
        .CNT_W     (16),
        .MAX_CYCLES(16'd8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Instruction(Instruction),
        .RegWrEnIn  (RegWrEnIn),
        .MemWrEnIn  (MemWrEnIn),
        .PCInit     (PCInit),
        .PCEn       (PCEn),
        .RegWrEn    (RegWrEn),
        .MemWrEn    (MemWrEn),
        .Busy       (Busy),
        .Done       (Done),
        .Timeout    (Timeout),
        .CycleCount (CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic drive(input logic st, input logic [8:0] ins, input logic rw, input logic mw);
        @(negedge Clk);
        Start       = st;
        Instruction = ins;
        RegWrEnIn   = rw;
        MemWrEnIn   = mw;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; Start = 1'b0; Instruction = 9'h000; RegWrEnIn = 1'b0; MemWrEnIn = 1'b0;

        // Reset state
        drive(0, 9'h000, 1, 1);
        check("rst_busy", Busy, 0);
        check("rst_pcen", PCEn, 0);
        check("rst_regwr", RegWrEn, 0);
        check("rst_done", Done, 0);
        check("rst_cnt", CycleCount, 0);
        Reset = 1'b1;

        // Straight-line: three non-loads then halt
        drive(1, 9'h000, 0, 0);
        check("idle_pcinit", PCInit, 0);
        drive(0, 9'h000, 1, 0);
        check("init_pcinit", PCInit, 1);
        check("init_busy", Busy, 1);
        check("init_pcen", PCEn, 0);
        check("init_cnt", CycleCount, 0);
        drive(0, 9'h010, 1, 0);
        check("sl0_pcen", PCEn, 1);
        check("sl0_regwr", RegWrEn, 1);
        check("sl0_pcinit", PCInit, 0);
        drive(0, 9'h123, 0, 1);
        check("sl1_pcen", PCEn, 1);
        check("sl1_memwr", MemWrEn, 1);
        check("sl1_regwr", RegWrEn, 0);
        drive(0, 9'h0FF, 0, 0);
        check("sl2_pcen", PCEn, 1);
        check("sl2_cnt", CycleCount, 2);
        drive(0, 9'h1FF, 1, 1);
        check("halt_pcen", PCEn, 0);
        check("halt_regwr", RegWrEn, 0);
        check("halt_memwr", MemWrEn, 0);
        check("halt_done", Done, 0);
        drive(0, 9'h000, 1, 1);
        check("sl_done", Done, 1);
        check("sl_busy", Busy, 0);
        check("sl_cnt", CycleCount, 4);
        check("sl_timeout", Timeout, 0);
        check("sl_done_pcen", PCEn, 0);
        drive(0, 9'h000, 0, 0);
        check("idle_done_held", Done, 1);

        // Load (MEM_LAT=1) then halt
        drive(1, 9'h000, 0, 0);
        drive(0, 9'h000, 0, 0);
        check("ld_init_done", Done, 0);
        check("ld_init_cnt", CycleCount, 0);
        drive(0, 9'h085, 1, 1);
        check("ld0_pcen", PCEn, 0);
        check("ld0_regwr", RegWrEn, 0);
        check("ld0_memwr", MemWrEn, 0);
        drive(0, 9'h085, 1, 1);
        check("ld1_pcen", PCEn, 1);
        check("ld1_regwr", RegWrEn, 1);
        check("ld1_memwr", MemWrEn, 0);
        check("ld1_busy", Busy, 1);
        drive(0, 9'h1FF, 1, 0);
        check("ld_halt_pcen", PCEn, 0);
        drive(0, 9'h000, 0, 0);
        check("ld_done", Done, 1);
        check("ld_cnt", CycleCount, 3);
        check("ld_timeout", Timeout, 0);

        // Timeout: six non-loads, then a load whose wait hits the budget
        drive(0, 9'h000, 0, 0);
        drive(1, 9'h000, 0, 0);
        drive(0, 9'h000, 1, 0);
        check("to_pcinit", PCInit, 1);
        for (int i = 0; i < 6; i++) begin
            drive((i == 2), 9'h001, 1, 0);
            check("to_loop_pcen", PCEn, 1);
            check("to_loop_cnt", CycleCount, i);
        end
        drive(0, 9'h08A, 1, 0);
        check("to_ld_pcen", PCEn, 0);
        check("to_ld_cnt", CycleCount, 6);
        drive(0, 9'h08A, 1, 1);
        check("to_last_cnt", CycleCount, 7);
        check("to_last_pcen", PCEn, 0);
        check("to_last_regwr", RegWrEn, 0);
        check("to_last_memwr", MemWrEn, 0);
        drive(1, 9'h000, 1, 1);
        check("to_done", Done, 1);
        check("to_timeout", Timeout, 1);
        check("to_cnt", CycleCount, 8);
        check("to_busy", Busy, 0);

        // Restart handshake
        drive(1, 9'h000, 0, 0);
        check("hold_done", Done, 1);
        check("hold_pcinit", PCInit, 0);
        check("hold_timeout", Timeout, 1);
        drive(0, 9'h000, 0, 0);
        drive(1, 9'h000, 0, 0);
        check("re_idle_busy", Busy, 0);
        drive(0, 9'h000, 0, 0);
        check("re_pcinit", PCInit, 1);
        check("re_cnt", CycleCount, 0);
        check("re_timeout", Timeout, 0);
        check("re_done", Done, 0);

        // Reset asserted mid-load
        drive(0, 9'h08F, 1, 0);
        check("rl_ld_pcen", PCEn, 0);
        drive(0, 9'h08F, 1, 0);
        check("rl_wait_pcen", PCEn, 1);
        check("rl_wait_busy", Busy, 1);
        #1 Reset = 1'b0;
        #1;
        check("rl_busy", Busy, 0);
        check("rl_pcen", PCEn, 0);
        check("rl_regwr", RegWrEn, 0);
        check("rl_cnt", CycleCount, 0);
        drive(0, 9'h000, 0, 0);
        Reset = 1'b1;
        drive(0, 9'h000, 1, 1);
        check("post_rst_busy", Busy, 0);
        check("post_rst_memwr", MemWrEn, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
